// File: rtl/tlb_search_unit_pkg.sv
// Shared definitions for the TLB search unit: entry/page/result layouts,
// INVTLB operation codes and the sweep FSM state type.
package tlb_search_unit_pkg;

  // Result index field is sized for the largest supported array (64 entries);
  // smaller arrays zero-extend their index into it.
  localparam int unsigned TLB_IDX_W = 6;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic        e;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  typedef struct packed {
    logic                 found;
    logic [TLB_IDX_W-1:0] index;
    logic [19:0]          ppn;
    logic [1:0]           plv;
    logic [1:0]           mat;
    logic                 d;
    logic                 v;
  } tlb_result_t;

  localparam logic [4:0] INVTLB_ALL0       = 5'd0;
  localparam logic [4:0] INVTLB_ALL1       = 5'd1;
  localparam logic [4:0] INVTLB_G1         = 5'd2;
  localparam logic [4:0] INVTLB_G0         = 5'd3;
  localparam logic [4:0] INVTLB_G0_ASID    = 5'd4;
  localparam logic [4:0] INVTLB_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INVTLB_GASID_VA   = 5'd6;

  typedef enum logic {
    INV_IDLE,
    INV_SWEEP
  } inv_state_e;

endpackage

// File: rtl/tlb_search_unit_if.sv
// Bus between the MMU requesters (translators, CSR stage) and the TLB search
// unit. master = requester side, slave = tlb_search_unit.
//   s0_* / s1_* : fetch / data search request and registered result
//   w_*         : entry write port (no handshake)
//   r_*         : entry read port (registered data)
//   inv_*       : INVTLB request handshake and completion pulse
interface tlb_search_unit_if #(
  parameter int unsigned IDXW = 4
);
  import tlb_search_unit_pkg::*;

  logic [18:0]     s0_vppn;
  logic            s0_va_bit12;
  logic [9:0]      s0_asid;
  tlb_result_t     s0_result;
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  tlb_result_t     s1_result;

  logic            w_en;
  logic [IDXW-1:0] w_index;
  tlb_entry_t      w_entry;

  logic [IDXW-1:0] r_index;
  tlb_entry_t      r_entry;

  logic            inv_valid;
  logic            inv_ready;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;
  logic            inv_done;

  modport master (
    output s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
    output w_en, w_index, w_entry, r_index,
    output inv_valid, inv_op, inv_asid, inv_vppn,
    input  s0_result, s1_result, r_entry, inv_ready, inv_done
  );

  modport slave (
    input  s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
    input  w_en, w_index, w_entry, r_index,
    input  inv_valid, inv_op, inv_asid, inv_vppn,
    output s0_result, s1_result, r_entry, inv_ready, inv_done
  );

endinterface

// File: rtl/tlb_search_unit_entry_match.sv
// tlb_entry_match: compares one TLB entry against a search vppn/asid and
// returns the hit flag plus the page selected by va_bit12.
//   entry     : stored TLB entry
//   vppn/asid : search key
//   va_bit12  : 1 selects the odd page
//   hit       : entry valid and key matches (global entries ignore asid)
//   page      : selected page fields (meaningful only when hit)
module tlb_entry_match
  import tlb_search_unit_pkg::*;
(
  input  tlb_entry_t  entry,
  input  logic [18:0] vppn,
  input  logic        va_bit12,
  input  logic [9:0]  asid,
  output logic        hit,
  output tlb_page_t   page
);

  assign hit  = entry.e && (entry.vppn == vppn) && (entry.g || (entry.asid == asid));
  assign page = va_bit12 ? entry.p1 : entry.p0;

endmodule

// File: rtl/tlb_search_unit.sv
// tlb_search_unit: TLB array with two registered search ports, a write port,
// a registered read port and a one-entry-per-cycle INVTLB sweep.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : tlb_search_unit_if.slave (search, write, read, INVTLB)
// Build option: define TLB_WRITE_FORWARD_EN to make same-cycle searches and
// reads observe that cycle's write / sweep clear.
module tlb_search_unit
  import tlb_search_unit_pkg::*;
#(
  parameter int unsigned TLBNUM = 16
) (
  input  logic              clk,
  input  logic              resetn,
  tlb_search_unit_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(TLBNUM);

  tlb_entry_t      mem_q [TLBNUM];
  tlb_entry_t      mem_d [TLBNUM];
  tlb_entry_t      view  [TLBNUM];

  inv_state_e      state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [4:0]      op_q;
  logic [9:0]      asid_q;
  logic [18:0]     vppn_q;
  logic            accept;
  logic            sweep_last;
  logic            clr_en;
  logic            done_q;

  logic [TLBNUM-1:0] hit0, hit1;
  tlb_page_t         pg0 [TLBNUM];
  tlb_page_t         pg1 [TLBNUM];
  tlb_result_t       res0_d, res1_d;

  function automatic logic inv_hit(input tlb_entry_t ent, input logic [4:0] op,
                                   input logic [9:0] asid, input logic [18:0] vppn);
    logic asid_eq;
    logic vppn_eq;
    asid_eq = (ent.asid == asid);
    vppn_eq = (ent.vppn == vppn);
    case (op)
      INVTLB_ALL0, INVTLB_ALL1: inv_hit = 1'b1;
      INVTLB_G1:                inv_hit = ent.g;
      INVTLB_G0:                inv_hit = !ent.g;
      INVTLB_G0_ASID:           inv_hit = !ent.g && asid_eq;
      INVTLB_G0_ASID_VA:        inv_hit = !ent.g && asid_eq && vppn_eq;
      INVTLB_GASID_VA:          inv_hit = (ent.g || asid_eq) && vppn_eq;
      default:                  inv_hit = 1'b0;
    endcase
  endfunction

  // Sweep FSM
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    sweep_last    = 1'b0;
    bus.inv_ready = 1'b0;
    unique case (state_q)
      INV_IDLE: begin
        bus.inv_ready = 1'b1;
        if (bus.inv_valid) begin
          accept  = 1'b1;
          state_d = INV_SWEEP;
          cnt_d   = '0;
        end
      end
      INV_SWEEP: begin
        cnt_d = cnt_q + IDXW'(1);
        if (cnt_q == IDXW'(TLBNUM - 1)) begin
          sweep_last = 1'b1;
          state_d    = INV_IDLE;
          cnt_d      = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= INV_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= sweep_last;
      if (accept) begin
        op_q   <= bus.inv_op;
        asid_q <= bus.inv_asid;
        vppn_q <= bus.inv_vppn;
      end
    end
  end

  assign bus.inv_done = done_q;

  // Only the entry under the sweep pointer is examined each cycle.
  assign clr_en = (state_q == INV_SWEEP) && inv_hit(mem_q[cnt_q], op_q, asid_q, vppn_q);

  // Next array contents; a write to the index being swept takes priority.
  always_comb begin
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      mem_d[i] = mem_q[i];
      if (bus.w_en && (bus.w_index == IDXW'(i))) begin
        mem_d[i] = bus.w_entry;
      end else if (clr_en && (cnt_q == IDXW'(i))) begin
        mem_d[i].e = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < TLBNUM; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < TLBNUM; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Array image seen by the search and read ports.
  always_comb begin
    for (int unsigned i = 0; i < TLBNUM; i++) begin
`ifdef TLB_WRITE_FORWARD_EN
      view[i] = mem_d[i];
`else
      view[i] = mem_q[i];
`endif
    end
  end

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
    tlb_entry_match u_match0 (
      .entry    (view[gi]),
      .vppn     (bus.s0_vppn),
      .va_bit12 (bus.s0_va_bit12),
      .asid     (bus.s0_asid),
      .hit      (hit0[gi]),
      .page     (pg0[gi])
    );
    tlb_entry_match u_match1 (
      .entry    (view[gi]),
      .vppn     (bus.s1_vppn),
      .va_bit12 (bus.s1_va_bit12),
      .asid     (bus.s1_asid),
      .hit      (hit1[gi]),
      .page     (pg1[gi])
    );
  end

  // Lowest-index hit wins; a miss leaves every field zero.
  always_comb begin
    res0_d = '0;
    res1_d = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (hit0[i] && !res0_d.found) begin
        res0_d.found = 1'b1;
        res0_d.index = TLB_IDX_W'(i);
        {res0_d.ppn, res0_d.plv, res0_d.mat, res0_d.d, res0_d.v} = pg0[i];
      end
      if (hit1[i] && !res1_d.found) begin
        res1_d.found = 1'b1;
        res1_d.index = TLB_IDX_W'(i);
        {res1_d.ppn, res1_d.plv, res1_d.mat, res1_d.d, res1_d.v} = pg1[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.s0_result <= '0;
      bus.s1_result <= '0;
      bus.r_entry   <= '0;
    end else begin
      bus.s0_result <= res0_d;
      bus.s1_result <= res1_d;
      bus.r_entry   <= view[bus.r_index];
    end
  end

endmodule

// File: tb/tb_tlb_search_unit.sv
module tb_tlb_search_unit;
  import tlb_search_unit_pkg::*;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tlb_search_unit_if #(.IDXW(IDXW)) bus();

  tlb_search_unit #(.TLBNUM(TLBNUM)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_seen = 0;

  tlb_entry_t  ref_mem [TLBNUM];
  tlb_result_t exp0_q[$], exp1_q[$];
  tlb_entry_t  expr_q[$];
  string       tag0_q[$], tag1_q[$], tagr_q[$];
  logic        s0_issued = 1'b0, s1_issued = 1'b0, r_issued = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic tlb_entry_t mk_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                          input logic g, input logic [19:0] ppn0, input logic [19:0] ppn1);
    tlb_entry_t en;
    en      = '0;
    en.vppn = vppn;
    en.asid = asid;
    en.g    = g;
    en.e    = 1'b1;
    en.p0   = '{ppn: ppn0, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    en.p1   = '{ppn: ppn1, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    return en;
  endfunction

  function automatic tlb_result_t model_search(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
    tlb_result_t r;
    tlb_page_t   p;
    r = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (ref_mem[i].e && ref_mem[i].vppn == vppn && (ref_mem[i].g || ref_mem[i].asid == asid)) begin
        p = b12 ? ref_mem[i].p1 : ref_mem[i].p0;
        r = '{found: 1'b1, index: TLB_IDX_W'(i), ppn: p.ppn, plv: p.plv, mat: p.mat, d: p.d, v: p.v};
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic model_inv(input tlb_entry_t en, input int op, input logic [9:0] asid, input logic [18:0] vppn);
    case (op)
      0, 1:    return 1'b1;
      2:       return en.g;
      3:       return !en.g;
      4:       return !en.g && en.asid == asid;
      5:       return !en.g && en.asid == asid && en.vppn == vppn;
      6:       return (en.g || en.asid == asid) && en.vppn == vppn;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: compare every result whose request was presented at this edge.
  task automatic tick();
    logic p0, p1, pr;
    p0 = s0_issued;
    p1 = s1_issued;
    pr = r_issued;
    @(posedge clk);
    #1;
    s0_issued = 1'b0;
    s1_issued = 1'b0;
    r_issued  = 1'b0;
    if (p0) check(tag0_q.pop_front(), 128'(bus.s0_result), 128'(exp0_q.pop_front()));
    if (p1) check(tag1_q.pop_front(), 128'(bus.s1_result), 128'(exp1_q.pop_front()));
    if (pr) check(tagr_q.pop_front(), 128'(bus.r_entry),   128'(expr_q.pop_front()));
    if (bus.inv_done) done_seen++;
  endtask

  task automatic search(input int port, input string tag, input logic [18:0] vppn,
                        input logic b12, input logic [9:0] asid, input tlb_result_t exp);
    if (port == 0) begin
      bus.s0_vppn = vppn; bus.s0_va_bit12 = b12; bus.s0_asid = asid;
      s0_issued = 1'b1; exp0_q.push_back(exp); tag0_q.push_back(tag);
    end else begin
      bus.s1_vppn = vppn; bus.s1_va_bit12 = b12; bus.s1_asid = asid;
      s1_issued = 1'b1; exp1_q.push_back(exp); tag1_q.push_back(tag);
    end
  endtask

  task automatic rd(input string tag, input int idx, input tlb_entry_t exp);
    bus.r_index = IDXW'(idx);
    r_issued = 1'b1;
    expr_q.push_back(exp);
    tagr_q.push_back(tag);
  endtask

  task automatic wr(input int idx, input tlb_entry_t en);
    bus.w_en = 1'b1;
    bus.w_index = IDXW'(idx);
    bus.w_entry = en;
    tick();
    bus.w_en = 1'b0;
    ref_mem[idx] = en;
  endtask

  // Full INVTLB sweep with an optional write presented in sweep cycle wr_cycle (1-based).
  task automatic invtlb(input string tag, input int op, input logic [9:0] asid, input logic [18:0] vppn,
                        input int wr_cycle, input int wr_idx, input tlb_entry_t wr_ent);
    int unsigned waitc;
    int unsigned low;
    int unsigned done0;
    waitc = 0;
    low = 0;
    while (!bus.inv_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    check({tag, "_ready_before"}, 128'(bus.inv_ready), 128'(1'b1));
    bus.inv_valid = 1'b1;
    bus.inv_op = 5'(op);
    bus.inv_asid = asid;
    bus.inv_vppn = vppn;
    tick();
    bus.inv_valid = 1'b0;
    done0 = done_seen;
    for (int c = 1; c <= TLBNUM; c++) begin
      if (!bus.inv_ready) low++;
      if (c == wr_cycle) begin
        bus.w_en = 1'b1;
        bus.w_index = IDXW'(wr_idx);
        bus.w_entry = wr_ent;
      end
      tick();
      bus.w_en = 1'b0;
      if (c == wr_cycle) ref_mem[wr_idx] = wr_ent;
      if (!(c == wr_cycle && wr_idx == c - 1) && model_inv(ref_mem[c-1], op, asid, vppn))
        ref_mem[c-1].e = 1'b0;
    end
    check({tag, "_ready_low_cycles"}, 128'(low), 128'(TLBNUM));
    check({tag, "_ready_after"}, 128'(bus.inv_ready), 128'(1'b1));
    check({tag, "_done_high"}, 128'(bus.inv_done), 128'(1'b1));
    tick();
    check({tag, "_done_pulses"}, 128'(done_seen - done0), 128'(1));
    check({tag, "_done_low"}, 128'(bus.inv_done), 128'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tlb_entry_t  ea, eb, none;
    tlb_result_t exp_fw, exp_a;
    int unsigned done0;

    none = '0;
    resetn = 1'b0;
    bus.s0_vppn = '0; bus.s0_va_bit12 = 1'b0; bus.s0_asid = '0;
    bus.s1_vppn = '0; bus.s1_va_bit12 = 1'b0; bus.s1_asid = '0;
    bus.w_en = 1'b0; bus.w_index = '0; bus.w_entry = '0; bus.r_index = '0;
    bus.inv_valid = 1'b0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_s0_result", 128'(bus.s0_result), 128'(0));
    check("rst_s1_result", 128'(bus.s1_result), 128'(0));
    check("rst_r_entry", 128'(bus.r_entry), 128'(0));
    check("rst_inv_ready", 128'(bus.inv_ready), 128'(1'b1));
    check("rst_inv_done", 128'(bus.inv_done), 128'(1'b0));
    resetn = 1'b1;
    tick();

    // Basic write / search / read
    ea = mk_entry(19'h12345, 10'd5, 1'b0, 20'hA0000, 20'hA0001);
    wr(3, ea);
    search(0, "hit_odd", 19'h12345, 1'b1, 10'd5,
           '{found: 1'b1, index: 6'd3, ppn: 20'hA0001, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    search(1, "miss_asid", 19'h12345, 1'b1, 10'd6, '0);
    rd("read_idx3", 3, ea);
    tick();
    search(0, "hit_even", 19'h12345, 1'b0, 10'd5,
           '{found: 1'b1, index: 6'd3, ppn: 20'hA0000, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    search(1, "hit_odd_p1", 19'h12345, 1'b1, 10'd5, model_search(19'h12345, 1'b1, 10'd5));
    rd("read_empty", 0, none);
    tick();

    // Duplicate global entries: lowest index wins on both ports
    wr(7, mk_entry(19'h0ABCD, 10'd9, 1'b1, 20'hC0007, 20'hD0007));
    wr(2, mk_entry(19'h0ABCD, 10'd1, 1'b1, 20'hC0002, 20'hD0002));
    search(0, "dup_p0", 19'h0ABCD, 1'b0, 10'h3FF,
           '{found: 1'b1, index: 6'd2, ppn: 20'hC0002, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    search(1, "dup_p1", 19'h0ABCD, 1'b1, 10'd0,
           '{found: 1'b1, index: 6'd2, ppn: 20'hD0002, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    tick();

    // Fill all entries with alternating g, then INVTLB op 2 (clear global)
    for (int i = 0; i < TLBNUM; i++)
      wr(i, mk_entry(19'(32'h100 + i), 10'(i), i[0], 20'(32'h10000 + i), 20'(32'h20000 + i)));
    invtlb("op2", 2, 10'd0, 19'd0, 0, 0, none);
    for (int i = 0; i < TLBNUM; i++) begin
      search(i % 2, $sformatf("op2_e%0d", i), 19'(32'h100 + i), i[1], 10'(i),
             model_search(19'(32'h100 + i), i[1], 10'(i)));
      tick();
    end
    search(0, "op2_even_kept", 19'h104, 1'b0, 10'd4,
           '{found: 1'b1, index: 6'd4, ppn: 20'h10004, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    search(1, "op2_odd_gone", 19'h105, 1'b0, 10'd5, '0);
    tick();

    // INVTLB op 5 with a concurrent write to index 15
    exp_a = '{found: 1'b1, index: 6'd15, ppn: 20'hA0001, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    invtlb("op5_early", 5, 10'd5, 19'h12345, 2, 15, ea);
    search(0, "op5_early_cleared", 19'h12345, 1'b1, 10'd5, '0);
    search(1, "op5_early_model", 19'h12345, 1'b1, 10'd5, model_search(19'h12345, 1'b1, 10'd5));
    tick();
    invtlb("op5_late", 5, 10'd5, 19'h12345, 16, 15, ea);
    search(0, "op5_late_survives", 19'h12345, 1'b1, 10'd5, exp_a);
    rd("op5_late_read", 15, ea);
    tick();

    // Same-cycle write and search of index 4
    eb = mk_entry(19'h0BEEF, 10'd7, 1'b1, 20'hB0000, 20'hB0001);
    bus.w_en = 1'b1;
    bus.w_index = IDXW'(4);
    bus.w_entry = eb;
`ifdef TLB_WRITE_FORWARD_EN
    exp_fw = '{found: 1'b1, index: 6'd4, ppn: 20'hB0000, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    ref_mem[4] = eb;
`else
    exp_fw = '0;
`endif
    search(0, "samecyc_new", 19'h0BEEF, 1'b0, 10'd3, exp_fw);
    search(1, "samecyc_old", 19'h104, 1'b0, 10'd4, model_search(19'h104, 1'b0, 10'd4));
    rd("samecyc_read", 4, ref_mem[4]);
    tick();
    bus.w_en = 1'b0;
    ref_mem[4] = eb;
    search(0, "after_write", 19'h0BEEF, 1'b1, 10'd3,
           '{found: 1'b1, index: 6'd4, ppn: 20'hB0001, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    tick();

    // Reset in sweep cycle 5 aborts the sweep
    bus.inv_valid = 1'b1;
    bus.inv_op = 5'd0;
    tick();
    bus.inv_valid = 1'b0;
    check("abort_ready_low", 128'(bus.inv_ready), 128'(1'b0));
    tick(); tick(); tick(); tick();
    resetn = 1'b0;
    #1;
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
    check("abort_s0_result", 128'(bus.s0_result), 128'(0));
    check("abort_s1_result", 128'(bus.s1_result), 128'(0));
    check("abort_r_entry", 128'(bus.r_entry), 128'(0));
    check("abort_ready", 128'(bus.inv_ready), 128'(1'b1));
    check("abort_done", 128'(bus.inv_done), 128'(1'b0));
    tick(); tick();
    resetn = 1'b1;
    done0 = done_seen;
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done", 128'(done_seen - done0), 128'(0));
    search(0, "abort_cleared", 19'h0BEEF, 1'b0, 10'd7, '0);
    tick();

    // Undefined op: full-length sweep, nothing cleared
    wr(0, mk_entry(19'h00042, 10'd2, 1'b0, 20'h00420, 20'h00421));
    wr(9, mk_entry(19'h00077, 10'd2, 1'b1, 20'h00770, 20'h00771));
    invtlb("op9", 9, 10'd2, 19'h00042, 0, 0, none);
    search(0, "op9_kept0", 19'h00042, 1'b1, 10'd2,
           '{found: 1'b1, index: 6'd0, ppn: 20'h00421, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1});
    search(1, "op9_kept9", 19'h00077, 1'b0, 10'd0, model_search(19'h00077, 1'b0, 10'd0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
